// File: rtl/controle_pkg.sv
// rtl/controle_pkg.sv - state encoding, timer width and default phase lengths for controle_movimento
package controle_pkg;

    typedef enum logic [2:0] {
        PARADO    = 3'd0,
        AVANCA    = 3'd1,
        RECUA     = 3'd2,
        GIRA      = 3'd3,
        ASPIRA    = 3'd4,
        BLOQUEADO = 3'd5
    } estado_t;

    localparam int T_RE_DEF     = 8;
    localparam int T_GIRA_DEF   = 12;
    localparam int T_ASPIRA_DEF = 16;
    localparam int TMR_W        = 5;

    // A phase of n cycles is timed by loading n-1 and leaving when the count hits zero.
    function automatic logic [TMR_W-1:0] carga(input int n);
        return TMR_W'(n - 1);
    endfunction

endpackage

// File: rtl/temporizador.sv
// rtl/temporizador.sv - 5-bit down-counter with load and zero flag, saturating at zero
module temporizador
    import controle_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] value,
    output logic             zero
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - TMR_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/controle_movimento.sv
// rtl/controle_movimento.sv - robot vacuum motion FSM with registered sensor inputs and Moore motor decode
module controle_movimento
    import controle_pkg::*;
#(
    parameter int T_RE     = T_RE_DEF,
    parameter int T_GIRA   = T_GIRA_DEF,
    parameter int T_ASPIRA = T_ASPIRA_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       liga,
    input  logic       bat_baixa,
    input  logic       obst_frente,
    input  logic       obst_esq,
    input  logic       obst_dir,
    input  logic       sujeira,
    output logic       mot_frente,
    output logic       mot_re,
    output logic       gira_esq,
    output logic       gira_dir,
    output logic       aspira,
    output logic [2:0] estado
);

    localparam logic [TMR_W-1:0] LD_RE     = carga(T_RE);
    localparam logic [TMR_W-1:0] LD_GIRA   = carga(T_GIRA);
    localparam logic [TMR_W-1:0] LD_ASPIRA = carga(T_ASPIRA);

    logic liga_q, bat_q, frente_q, esq_q, dir_q, suj_q;
    estado_t state_q, state_d;
    logic turn_right_q, turn_right_d;
    logic alt_right_q, alt_right_d;
    logic enter_gira;
    logic tmr_load, tmr_zero;
    logic [TMR_W-1:0] tmr_val;

    // Sensors are sampled first, so a fresh reset release cannot leave PARADO on its first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            liga_q       <= 1'b0;
            bat_q        <= 1'b0;
            frente_q     <= 1'b0;
            esq_q        <= 1'b0;
            dir_q        <= 1'b0;
            suj_q        <= 1'b0;
            state_q      <= PARADO;
            turn_right_q <= 1'b0;
            alt_right_q  <= 1'b0;
        end else begin
            liga_q       <= liga;
            bat_q        <= bat_baixa;
            frente_q     <= obst_frente;
            esq_q        <= obst_esq;
            dir_q        <= obst_dir;
            suj_q        <= sujeira;
            state_q      <= state_d;
            turn_right_q <= turn_right_d;
            alt_right_q  <= alt_right_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        turn_right_d = turn_right_q;
        alt_right_d  = alt_right_q;
        enter_gira   = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;

        if (!liga_q || bat_q) begin
            state_d = PARADO;
        end else begin
            case (state_q)
                PARADO: state_d = AVANCA;
                AVANCA: begin
                    if (frente_q) begin
                        state_d  = RECUA;
                        tmr_load = 1'b1;
                        tmr_val  = LD_RE;
                    end else if (suj_q) begin
                        state_d  = ASPIRA;
                        tmr_load = 1'b1;
                        tmr_val  = LD_ASPIRA;
                    end
                end
                RECUA: begin
                    if (tmr_zero) begin
                        if (esq_q && dir_q) state_d = BLOQUEADO;
                        else                enter_gira = 1'b1;
                    end
                end
                GIRA:      if (tmr_zero) state_d = AVANCA;
                ASPIRA:    if (tmr_zero) state_d = AVANCA;
                BLOQUEADO: if (!(esq_q && dir_q)) enter_gira = 1'b1;
                default:   state_d = PARADO;
            endcase
        end

        // Turn away from the blocked side; with both sides free, alternate starting left.
        if (enter_gira) begin
            state_d  = GIRA;
            tmr_load = 1'b1;
            tmr_val  = LD_GIRA;
            if (esq_q) begin
                turn_right_d = 1'b1;
            end else if (dir_q) begin
                turn_right_d = 1'b0;
            end else begin
                turn_right_d = alt_right_q;
                alt_right_d  = ~alt_right_q;
            end
        end
    end

    temporizador u_temporizador (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_val),
        .zero  (tmr_zero)
    );

    assign mot_frente = (state_q == AVANCA);
    assign mot_re     = (state_q == RECUA);
    assign gira_esq   = (state_q == GIRA) && !turn_right_q;
    assign gira_dir   = (state_q == GIRA) && turn_right_q;
    assign aspira     = (state_q == AVANCA) || (state_q == ASPIRA);
    assign estado     = state_q;

endmodule
